// File: rtl/tmds_timing_param.sv
// tmds_timing_param
//   Video timing extractor for the TMDS receiver, rx0_pclk domain. It sits
//   after the DVI decoder and feeds the line FIFO/packetiser. Sync polarity
//   is normalised, the active window is tracked, and active pixels and lines
//   are counted. An index is emitted that advances SEGS times per active line.
//   A frame-lock FSM marks the timing as stable once consecutive frames
//   measure identically.
//
//   Optional build macro: TMDS_TIMING_MEASURE_EN
//     defined   : meas_htotal/meas_vtotal capture the measured line/frame
//                 totals at each vsync rising edge
//     undefined : meas_htotal/meas_vtotal are tied to 0 (the lock logic is
//                 unchanged)
//
// Ports
//   rx0_pclk     in   pixel clock
//   rstbtn_n     in   asynchronous active-low reset
//   rx0_hsync    in   raw hsync from decoder (polarity per HS_POL)
//   rx0_vsync    in   raw vsync from decoder (polarity per VS_POL)
//   video_en     out  hactive & vactive
//   index        out  segment index (IDX_W)
//   video_hcnt   out  active pixel count within line (HCNT_W)
//   video_vcnt   out  active line count within frame (VCNT_W)
//   locked       out  timing stable
//   lock_lost    out  1-cycle pulse when lock is dropped
//   meas_htotal  out  measured clocks per line (HCNT_W)
//   meas_vtotal  out  measured lines per frame (VCNT_W)
module tmds_timing_param #(
  parameter int unsigned HCNT_W   = 12,
  parameter int unsigned VCNT_W   = 11,
  parameter int unsigned IDX_W    = 12,
  parameter int unsigned H_START  = 219,
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_START  = 19,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned SEGS     = 2,
  parameter int unsigned SEG_LEN  = 640,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned LOCK_FRM = 2
) (
  input  logic              rx0_pclk,
  input  logic              rstbtn_n,
  input  logic              rx0_hsync,
  input  logic              rx0_vsync,
  output logic              video_en,
  output logic [IDX_W-1:0]  index,
  output logic [HCNT_W-1:0] video_hcnt,
  output logic [VCNT_W-1:0] video_vcnt,
  output logic              locked,
  output logic              lock_lost,
  output logic [HCNT_W-1:0] meas_htotal,
  output logic [VCNT_W-1:0] meas_vtotal
);

  localparam logic [HCNT_W-1:0] H_ONE  = HCNT_W'(1);
  localparam logic [VCNT_W-1:0] V_ONE  = VCNT_W'(1);
  localparam logic [IDX_W-1:0]  I_ONE  = IDX_W'(1);
  localparam logic [HCNT_W-1:0] H_SET  = HCNT_W'(H_START);
  localparam logic [HCNT_W-1:0] H_CLR  = HCNT_W'(H_START + H_ACTIVE);
  localparam logic [VCNT_W-1:0] V_SET  = VCNT_W'(V_START);
  localparam logic [VCNT_W-1:0] V_CLR  = VCNT_W'(V_START + V_ACTIVE);
  localparam logic [3:0]        LOCK_N = 4'(LOCK_FRM);

  typedef enum logic [1:0] {
    SEARCH,
    CHECK,
    LOCKED
  } state_t;

  logic              hs, vs, hs_q, vs_q, hs_edge, vs_edge;
  logic [HCNT_W-1:0] hcounter;
  logic [VCNT_W-1:0] vcounter;
  logic              hsat;
  logic              hactive, vactive;
  logic              seg_hit;

  logic [HCNT_W-1:0] hlen_cnt, hlen_last, cur_h, ref_h;
  logic [VCNT_W-1:0] vlen, cur_v, ref_v;
  logic              match;

  state_t            state, state_n;
  logic [3:0]        match_cnt, match_cnt_n;
  logic              lost_n;

  // Normalise to active-high syncs
  assign hs      = rx0_hsync ^ ~HS_POL;
  assign vs      = rx0_vsync ^ ~VS_POL;
  assign hs_edge = hs & ~hs_q;
  assign vs_edge = vs & ~vs_q;
  assign hsat    = &hcounter;

  assign video_en = hactive & vactive;

  always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      hcounter <= '0;
      vcounter <= '0;
      hactive  <= 1'b0;
      vactive  <= 1'b0;
    end else begin
      hs_q <= hs;
      vs_q <= vs;

      if (hs)         hcounter <= '0;
      else if (!hsat) hcounter <= hcounter + H_ONE;

      if (vs)           vcounter <= '0;
      else if (hs_edge) vcounter <= vcounter + V_ONE;

      if (hcounter == H_SET)      hactive <= 1'b1;
      else if (hcounter == H_CLR) hactive <= 1'b0;

      if (vcounter == V_SET)      vactive <= 1'b1;
      else if (vcounter == V_CLR) vactive <= 1'b0;
    end
  end

  // Segment boundaries after the first one inside the active line
  always_comb begin
    seg_hit = 1'b0;
    for (int unsigned k = 1; k < SEGS; k++) begin
      if (hcounter == HCNT_W'(H_START + k * SEG_LEN)) seg_hit = 1'b1;
    end
  end

  always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      video_hcnt <= '0;
      video_vcnt <= '0;
      index      <= '0;
    end else begin
      video_hcnt <= video_en ? video_hcnt + H_ONE : '0;

      if (!vactive)     video_vcnt <= '0;
      else if (hs_edge) video_vcnt <= video_vcnt + V_ONE;

      // The clear is not gated by vactive, so blanking lines park the index at 0
      // and the first active line always starts from 0.
      if (hcounter == H_SET) begin
        if (video_vcnt == '0) index <= '0;
        else if (vactive)     index <= index + I_ONE;
      end else if (seg_hit && vactive) begin
        index <= index + I_ONE;
      end
    end
  end

  // A coincident hs_edge belongs to the closing line/frame
  assign cur_h = hs_edge ? hlen_cnt : hlen_last;
  assign cur_v = hs_edge ? vlen + V_ONE : vlen;
  assign match = (cur_h == ref_h) && (cur_v == ref_v);

  always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      hlen_cnt  <= '0;
      hlen_last <= '0;
      vlen      <= '0;
      ref_h     <= '0;
      ref_v     <= '0;
    end else begin
      if (hs_edge) begin
        hlen_cnt  <= H_ONE;
        hlen_last <= hlen_cnt;
      end else if (!(&hlen_cnt)) begin
        hlen_cnt <= hlen_cnt + H_ONE;
      end

      if (vs_edge) begin
        vlen  <= '0;
        ref_h <= cur_h;
        ref_v <= cur_v;
      end else if (hs_edge) begin
        vlen <= vlen + V_ONE;
      end
    end
  end

  always_comb begin
    state_n     = state;
    match_cnt_n = match_cnt;
    lost_n      = 1'b0;
    if (hsat) begin
      // No hsync for a whole counter span: timing is gone
      state_n     = SEARCH;
      match_cnt_n = '0;
      lost_n      = (state == LOCKED);
    end else if (vs_edge) begin
      unique case (state)
        SEARCH: begin
          state_n     = CHECK;
          match_cnt_n = '0;
        end
        CHECK: begin
          if (match) begin
            match_cnt_n = match_cnt + 4'd1;
            if (match_cnt + 4'd1 == LOCK_N) state_n = LOCKED;
          end else begin
            match_cnt_n = '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            state_n = SEARCH;
            lost_n  = 1'b1;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      state     <= SEARCH;
      match_cnt <= '0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_n;
      match_cnt <= match_cnt_n;
      locked    <= (state_n == LOCKED);
      lock_lost <= lost_n;
    end
  end

`ifdef TMDS_TIMING_MEASURE_EN
  always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      meas_htotal <= '0;
      meas_vtotal <= '0;
    end else if (vs_edge) begin
      meas_htotal <= cur_h;
      meas_vtotal <= cur_v;
    end
  end
`else
  assign meas_htotal = '0;
  assign meas_vtotal = '0;
`endif

endmodule

// File: tb/tb_tmds_timing_param.sv
// Testbench for tmds_timing_param: a randomized compact video stream
// (inverted sync polarity, small window) checked through expectation queues.
module tb_tmds_timing_param;

  localparam int HCNT_W   = 8;
  localparam int VCNT_W   = 6;
  localparam int IDX_W    = 4;
  localparam int H_START  = 10;
  localparam int H_ACTIVE = 40;
  localparam int V_START  = 3;
  localparam int V_ACTIVE = 6;
  localparam int SEGS     = 3;
  localparam int SEG_LEN  = 12;
  localparam int LOCK_FRM = 2;
  localparam bit HS_POL   = 1'b0;
  localparam bit VS_POL   = 1'b0;

  localparam int VS_LINES = 2;
  localparam int HOLE_LEN = 300;
  localparam int NFRAMES  = 36;
  localparam int HMAX     = (1 << HCNT_W) - 1;
  localparam int IDX_MOD  = 1 << IDX_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              hs_act, vs_act;
  logic              rx0_hsync, rx0_vsync;
  logic              video_en, locked, lock_lost;
  logic [IDX_W-1:0]  index;
  logic [HCNT_W-1:0] video_hcnt, meas_htotal;
  logic [VCNT_W-1:0] video_vcnt, meas_vtotal;
  bit                mon_off;

  always #5 clk = ~clk;

  assign rx0_hsync = hs_act ^ ~HS_POL;
  assign rx0_vsync = vs_act ^ ~VS_POL;

  tmds_timing_param #(
    .HCNT_W(HCNT_W), .VCNT_W(VCNT_W), .IDX_W(IDX_W),
    .H_START(H_START), .H_ACTIVE(H_ACTIVE),
    .V_START(V_START), .V_ACTIVE(V_ACTIVE),
    .SEGS(SEGS), .SEG_LEN(SEG_LEN),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .LOCK_FRM(LOCK_FRM)
  ) dut (
    .rx0_pclk(clk), .rstbtn_n(rst_n),
    .rx0_hsync(rx0_hsync), .rx0_vsync(rx0_vsync),
    .video_en(video_en), .index(index),
    .video_hcnt(video_hcnt), .video_vcnt(video_vcnt),
    .locked(locked), .lock_lost(lock_lost),
    .meas_htotal(meas_htotal), .meas_vtotal(meas_vtotal)
  );

  typedef struct { int run; int idx0; int idx1; int vcnt; } line_exp_t;
  typedef struct { int h; int v; } meas_t;

  line_exp_t line_q[$];
  int        lock_q[$];   // 1: lock acquired, 2: lock lost
  meas_t     meas_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic no_exp(input string name);
    checks++;
    failures++;
    $display("FAIL %s: DUT output with no expectation queued at %0t", name, $time);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_video_en"},    int'(video_en),    0);
    chk({tag, "_index"},       int'(index),       0);
    chk({tag, "_video_hcnt"},  int'(video_hcnt),  0);
    chk({tag, "_video_vcnt"},  int'(video_vcnt),  0);
    chk({tag, "_locked"},      int'(locked),      0);
    chk({tag, "_lock_lost"},   int'(lock_lost),   0);
    chk({tag, "_meas_htotal"}, int'(meas_htotal), 0);
    chk({tag, "_meas_vtotal"}, int'(meas_vtotal), 0);
  endtask

  // Reference model: frame statistics and lock rules
  int cur_h = -1, cur_v = -1;   // -1: frame cut short by reset, never matches
  int ref_h = -1, ref_v = -1;
  bit armed = 0, m_locked = 0;
  int streak = 0;

  task automatic model_edge();
    meas_t m;
    bit    same;
    same = (cur_h >= 0) && (cur_h == ref_h) && (cur_v == ref_v);
    if (!armed) begin
      armed  = 1;
      streak = 0;
    end else if (m_locked) begin
      if (!same) begin
        m_locked = 0;
        armed    = 0;
        lock_q.push_back(2);
      end
    end else if (same) begin
      streak++;
      if (streak == LOCK_FRM) begin
        m_locked = 1;
        lock_q.push_back(1);
      end
    end else begin
      streak = 0;
    end
    ref_h = cur_h;
    ref_v = cur_v;
`ifdef TMDS_TIMING_MEASURE_EN
    m.h = cur_h;
    m.v = cur_v;
`else
    m.h = 0;
    m.v = 0;
`endif
    meas_q.push_back(m);
  endtask

  task automatic model_hole();
    if (m_locked) lock_q.push_back(2);
    m_locked = 0;
    armed    = 0;
  endtask

  task automatic run_line(input int len, input bit vs_on, input int l);
    int        hsw;
    int        vline;
    line_exp_t e;
    hsw   = int'($urandom_range(6, 2));
    vline = (l >= VS_LINES) ? l - VS_LINES + 1 : 0;
    if (vline >= V_START && vline < V_START + V_ACTIVE) begin
      e.run  = H_ACTIVE;
      e.idx0 = ((vline - V_START) * SEGS) % IDX_MOD;
      e.idx1 = ((vline - V_START) * SEGS + SEGS - 1) % IDX_MOD;
      e.vcnt = vline - V_START;
      line_q.push_back(e);
    end
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      hs_act = (c < hsw);
      vs_act = vs_on;
    end
  endtask

  task automatic run_frame(input int htot, input int vtot, input int hole);
    int len;
    len = htot;
    model_edge();
    for (int l = 0; l < vtot; l++) begin
      len = (l == hole) ? HOLE_LEN : htot;
      if (l == hole) model_hole();
      run_line(len, l < VS_LINES, l);
    end
    cur_h = (len > HMAX) ? HMAX : len;
    cur_v = vtot;
  endtask

  // Monitor
  initial begin
    bit    prev_en, prev_locked, prev_lost, vs_prev, vs_pend;
    int    run, idx0, idx_last, ev;
    line_exp_t e;
    meas_t m;
    prev_en = 0; prev_locked = 0; prev_lost = 0; vs_prev = 0; vs_pend = 0;
    run = 0; idx0 = 0; idx_last = 0; ev = 0;
    forever begin
      @(negedge clk);
      if (rst_n && !mon_off) begin
        if (video_en) begin
          if (!prev_en) begin
            run  = 0;
            idx0 = int'(index);
          end
          run++;
          idx_last = int'(index);
        end else if (prev_en) begin
          if (line_q.size() == 0) no_exp("line_end");
          else begin
            e = line_q.pop_front();
            chk("line_run_len", run, e.run);
            chk("line_index_start", idx0, e.idx0);
            chk("line_index_end", idx_last, e.idx1);
            chk("line_video_vcnt", int'(video_vcnt), e.vcnt);
            chk("line_video_hcnt", int'(video_hcnt), H_ACTIVE);
          end
        end
        prev_en = video_en;

        ev = 0;
        if (lock_lost) begin
          ev = 2;
          chk("lost_clears_locked", int'(locked), 0);
          chk("lost_was_locked", int'(prev_locked), 1);
          chk("lost_single_cycle", int'(prev_lost), 0);
        end else if (locked && !prev_locked) begin
          ev = 1;
        end else if (!locked && prev_locked) begin
          chk("lock_drop_pulse", int'(lock_lost), 1);
        end
        if (ev != 0) begin
          if (lock_q.size() == 0) no_exp("lock_event");
          else chk("lock_event", ev, lock_q.pop_front());
        end
        prev_locked = locked;
        prev_lost   = lock_lost;

        if (vs_pend) begin
          if (meas_q.size() == 0) no_exp("meas");
          else begin
            m = meas_q.pop_front();
            if (m.h >= 0) begin
              chk("meas_htotal", int'(meas_htotal), m.h);
              chk("meas_vtotal", int'(meas_vtotal), m.v);
            end
          end
        end
        vs_pend = vs_act && !vs_prev;
        vs_prev = vs_act;
      end
    end
  end

  // Stimulus
  initial begin
    int htot, vtot;
    rst_n   = 1'b0;
    hs_act  = 1'b0;
    vs_act  = 1'b0;
    mon_off = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    for (int f = 0; f < NFRAMES; f++) begin
      htot = 60;
      vtot = 12;
      if (f == 8) vtot = 11;
      if (f >= 20) begin
        if ($urandom_range(3, 0) == 0) htot = 61;
        if ($urandom_range(3, 0) == 0) vtot = 11;
      end
      run_frame(htot, vtot, (f == 14) ? 6 : -1);
    end

    // Final frame: reset lands in the middle of an active line
    model_edge();
    for (int l = 0; l < 6; l++) run_line(60, l < VS_LINES, l);
    repeat (3) @(posedge clk);
    #1;
    chk("line_q_drained", line_q.size(), 0);
    chk("lock_q_drained", lock_q.size(), 0);
    chk("meas_q_drained", meas_q.size(), 0);
    mon_off = 1'b1;
    for (int c = 0; c < 33; c++) begin
      @(posedge clk);
      #1;
      hs_act = (c < 3);
    end
    chk("pre_reset_video_en", int'(video_en), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
